// File: rtl/cr_kme_fifo_rr_arb.sv
// -----------------------------------------------------------------------------
// cr_kme_fifo_rr_arb
//
// Packet-aware round-robin arbiter. It merges the read sides of N_REQ KME
// staging FIFOs onto a single beat stream that leaves through one registered
// output stage.
//
// Once a requester's first non-eop beat is taken, the grant stays locked to
// that requester until its eop beat is taken. A beat watchdog breaks the lock
// on packets that run longer than MAX_BEATS beats.
//
// Handshakes:
//   Upstream: req_ack[i] is a combinational pop strobe. It is high only in a
//   cycle where the output register loads a beat from requester i.
//   Downstream: a beat transfers on any rising edge where
//   out_valid & out_ready. The output register can load a new beat when it is
//   empty or is being drained in the same cycle.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req_valid[N]       per-requester beat available (FIFO not empty)
//   req_data[N*W]      per-requester head beat, requester i at [i*W +: W]
//   req_eop[N]         per-requester last-beat flag
//   req_ack[N]         one-hot/zero pop strobe to the granted FIFO
//   out_valid          output register holds a beat
//   out_data[W]        registered beat
//   out_eop            registered eop flag
//   out_src            index of the requester that produced out_data
//   out_ready          downstream accept
//   pkt_err            one-cycle pulse, registered, after the watchdog fires
//   locked             arbiter is mid-packet (FSM in LOCK)
// -----------------------------------------------------------------------------
module cr_kme_fifo_rr_arb #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 106,
   parameter int MAX_BEATS = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   input  logic [N_REQ-1:0]           req_eop,
   output logic [N_REQ-1:0]           req_ack,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_eop,
   output logic [$clog2(N_REQ)-1:0]   out_src,
   input  logic                       out_ready,
   output logic                       pkt_err,
   output logic                       locked
);

   localparam int SRC_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [SRC_W-1:0]   ptr, ptr_n;
   logic [SRC_W-1:0]   lock_id, lock_id_n;
   logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
   logic               fire;

   logic [SRC_W-1:0]   arb_sel;
   logic               arb_found;
   logic [SRC_W-1:0]   sel;
   logic               sel_vld;
   logic               sel_eop;
   logic               load_ok;
   logic               load;

   // Round-robin search that starts one past the last granted requester.
   always_comb begin
      arb_sel   = '0;
      arb_found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!arb_found && req_valid[(int'(ptr) + k) % N_REQ]) begin
            arb_found = 1'b1;
            arb_sel   = SRC_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

   // In LOCK the locked requester is selected unconditionally. An idle
   // locked requester therefore stalls the stream instead of letting
   // another requester interleave.
   assign sel     = (state == LOCK) ? lock_id : arb_sel;
   assign sel_vld = req_valid[sel];
   assign sel_eop = req_eop[sel];
   assign load_ok = !out_valid || out_ready;
   // rst gates the pop so that no FIFO is popped while the arbiter is held
   // in reset.
   assign load    = load_ok && sel_vld && !rst;
   assign req_ack = load ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel) : '0;
   assign locked  = (state == LOCK);

   // Next-state logic for the FSM, the grant pointer and the beat watchdog.
   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      lock_id_n  = lock_id;
      beat_cnt_n = beat_cnt;
      fire       = 1'b0;
      if (load) begin
         unique case (state)
            ARB: begin
               ptr_n = sel;
               if (!sel_eop) begin
                  state_n    = LOCK;
                  lock_id_n  = sel;
                  beat_cnt_n = CNT_W'(1);
               end
            end
            LOCK: begin
               if (sel_eop) begin
                  state_n    = ARB;
                  beat_cnt_n = '0;
               end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                  // The runaway beat is still forwarded. Any later beats
                  // of the packet re-enter arbitration as new packets.
                  fire       = 1'b1;
                  state_n    = ARB;
                  beat_cnt_n = '0;
               end else begin
                  beat_cnt_n = beat_cnt + CNT_W'(1);
               end
            end
            default: state_n = ARB;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB;
         ptr      <= SRC_W'(N_REQ - 1);
         lock_id  <= '0;
         beat_cnt <= '0;
         pkt_err  <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         lock_id  <= lock_id_n;
         beat_cnt <= beat_cnt_n;
         pkt_err  <= fire;
      end
   end

   // Output register. It holds its contents while stalled or after it has
   // been drained with nothing to replace the beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_eop   <= 1'b0;
         out_src   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= req_data[sel*DATA_W +: DATA_W];
         out_eop   <= sel_eop;
         out_src   <= sel;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cr_kme_fifo_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_cr_kme_fifo_rr_arb
//
// Directed bench for cr_kme_fifo_rr_arb with N_REQ=4, DATA_W=106 and
// MAX_BEATS=64.
//
// Each requester models a FIFO. Its head beat is d(i, n): the requester
// index sits in bits [23:16] and the pop count n sits in bits [15:0]. The
// head advances whenever the FIFO is acked.
//
// Each step applies inputs on a falling edge and checks the outputs 1 ns
// later against hand-computed values. req_ack is checked for the current
// inputs. The out_* values are checked against the beat acked in the
// previous step.
// -----------------------------------------------------------------------------
module tb_cr_kme_fifo_rr_arb;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 106;
   localparam int MAX_BEATS = 64;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*DATA_W-1:0]  req_data;
   logic [N_REQ-1:0]         req_eop;
   logic [N_REQ-1:0]         req_ack;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_eop;
   logic [1:0]               out_src;
   logic                     out_ready;
   logic                     pkt_err;
   logic                     locked;

   int vectors     = 0;
   int miscompares = 0;
   int hd [N_REQ];

   always #5 clk = ~clk;

   cr_kme_fifo_rr_arb #(
      .N_REQ     (N_REQ),
      .DATA_W    (DATA_W),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_eop   (req_eop),
      .req_ack   (req_ack),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_eop   (out_eop),
      .out_src   (out_src),
      .out_ready (out_ready),
      .pkt_err   (pkt_err),
      .locked    (locked)
   );

   function automatic logic [DATA_W-1:0] d(input int i, input int n);
      logic [DATA_W-1:0] r;
      r        = '0;
      r[23:16] = i[7:0];
      r[15:0]  = n[15:0];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Applies one cycle of stimulus and checks the DUT outputs.
   task automatic step(input string tag, input logic r, input logic [3:0] v,
                       input logic [3:0] e, input logic rdy,
                       input logic [3:0] x_ack, input logic x_ov,
                       input logic [1:0] x_src, input logic [DATA_W-1:0] x_data,
                       input logic x_eop, input logic x_lock, input logic x_err);
      @(negedge clk);
      rst       = r;
      req_valid = v;
      req_eop   = e;
      out_ready = rdy;
      for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = d(i, hd[i]);
      #1;
      chk({tag, ".ack"},    DATA_W'(req_ack),   DATA_W'(x_ack));
      chk({tag, ".ovalid"}, DATA_W'(out_valid), DATA_W'(x_ov));
      chk({tag, ".src"},    DATA_W'(out_src),   DATA_W'(x_src));
      chk({tag, ".data"},   out_data,           x_data);
      chk({tag, ".eop"},    DATA_W'(out_eop),   DATA_W'(x_eop));
      chk({tag, ".locked"}, DATA_W'(locked),    DATA_W'(x_lock));
      chk({tag, ".pkterr"}, DATA_W'(pkt_err),   DATA_W'(x_err));
      // FIFO model: an acked head is popped at the coming rising edge.
      for (int i = 0; i < N_REQ; i++) if (req_ack[i]) hd[i]++;
   endtask

   initial begin
      for (int i = 0; i < N_REQ; i++) hd[i] = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_eop   = '0;
      req_data  = '0;
      out_ready = 1'b1;

      // Reset held with every requester valid.
      step("rst0", 1, 4'hF, 4'hF, 1, 4'h0, 0, 0, d(0,0) & '0, 0, 0, 0);
      step("rst1", 1, 4'hF, 4'hF, 1, 4'h0, 0, 0, '0, 0, 0, 0);
      step("rst2", 1, 4'hF, 4'hF, 1, 4'h0, 0, 0, '0, 0, 0, 0);

      // Fairness: single-beat packets from all four requesters.
      step("f1", 0, 4'hF, 4'hF, 1, 4'h1, 0, 0, '0,      0, 0, 0);
      step("f2", 0, 4'hF, 4'hF, 1, 4'h2, 1, 0, d(0,0),  1, 0, 0);
      step("f3", 0, 4'hF, 4'hF, 1, 4'h4, 1, 1, d(1,0),  1, 0, 0);
      step("f4", 0, 4'hF, 4'hF, 1, 4'h8, 1, 2, d(2,0),  1, 0, 0);
      step("f5", 0, 4'hF, 4'hF, 1, 4'h1, 1, 3, d(3,0),  1, 0, 0);
      step("f6", 0, 4'hF, 4'hF, 1, 4'h2, 1, 0, d(0,1),  1, 0, 0);
      step("f7", 0, 4'hF, 4'hF, 1, 4'h4, 1, 1, d(1,1),  1, 0, 0);
      step("f8", 0, 4'hF, 4'hF, 1, 4'h8, 1, 2, d(2,1),  1, 0, 0);
      step("f9", 0, 4'hF, 4'hF, 1, 4'h1, 1, 3, d(3,1),  1, 0, 0);
      step("f10",0, 4'hF, 4'hF, 1, 4'h2, 1, 0, d(0,2),  1, 0, 0);

      // Packet lock: requester 2 sends five beats while the others stay valid.
      // The stall in the middle keeps out_ready low for four cycles.
      step("p1", 0, 4'hF, 4'hB, 1, 4'h4, 1, 1, d(1,2),  1, 0, 0);
      step("p2", 0, 4'hF, 4'hB, 1, 4'h4, 1, 2, d(2,2),  0, 1, 0);
      step("p3", 0, 4'hF, 4'hB, 1, 4'h4, 1, 2, d(2,3),  0, 1, 0);
      step("bp1",0, 4'hF, 4'hB, 0, 4'h0, 1, 2, d(2,4),  0, 1, 0);
      step("bp2",0, 4'hF, 4'hB, 0, 4'h0, 1, 2, d(2,4),  0, 1, 0);
      step("bp3",0, 4'hF, 4'hB, 0, 4'h0, 1, 2, d(2,4),  0, 1, 0);
      step("bp4",0, 4'hF, 4'hB, 0, 4'h0, 1, 2, d(2,4),  0, 1, 0);
      step("p4", 0, 4'hF, 4'hB, 1, 4'h4, 1, 2, d(2,4),  0, 1, 0);
      step("p5", 0, 4'hF, 4'hF, 1, 4'h4, 1, 2, d(2,5),  0, 1, 0);
      step("p6", 0, 4'hF, 4'hF, 1, 4'h8, 1, 2, d(2,6),  1, 0, 0);

      // Locked requester 0 goes idle for three cycles mid-packet.
      step("i1", 0, 4'hF, 4'hE, 1, 4'h1, 1, 3, d(3,2),  1, 0, 0);
      step("i2", 0, 4'hE, 4'hE, 1, 4'h0, 1, 0, d(0,3),  0, 1, 0);
      step("i3", 0, 4'hE, 4'hE, 1, 4'h0, 0, 0, d(0,3),  0, 1, 0);
      step("i4", 0, 4'hE, 4'hE, 1, 4'h0, 0, 0, d(0,3),  0, 1, 0);
      step("i5", 0, 4'hF, 4'hF, 1, 4'h1, 0, 0, d(0,3),  0, 1, 0);
      step("i6", 0, 4'hF, 4'hF, 1, 4'h2, 1, 0, d(0,4),  1, 0, 0);

      // Watchdog: requester 1 streams without eop while requester 2 waits.
      step("w1", 0, 4'h2, 4'h0, 1, 4'h2, 1, 1, d(1,3),  1, 0, 0);
      for (int k = 2; k <= MAX_BEATS; k++)
         step($sformatf("wd%0d", k), 0, 4'h6, 4'h4, 1, 4'h2, 1, 1, d(1, 2 + k), 0, 1, 0);
      step("wa", 0, 4'h6, 4'h4, 1, 4'h4, 1, 1, d(1,67), 0, 0, 1);
      step("wb", 0, 4'h6, 4'h4, 1, 4'h2, 1, 2, d(2,7),  1, 0, 0);
      step("wc", 0, 4'h6, 4'h6, 1, 4'h2, 1, 1, d(1,68), 0, 1, 0);
      step("wd", 0, 4'h0, 4'h0, 1, 4'h0, 1, 1, d(1,69), 1, 0, 0);
      step("we", 0, 4'h0, 4'h0, 1, 4'h0, 0, 1, d(1,69), 1, 0, 0);

      // Reset asserted mid-packet.
      step("m1", 0, 4'h1, 4'h0, 1, 4'h1, 0, 1, d(1,69), 1, 0, 0);
      step("m2", 0, 4'h1, 4'h0, 1, 4'h1, 1, 0, d(0,5),  0, 1, 0);
      step("m3", 0, 4'h0, 4'h0, 1, 4'h0, 1, 0, d(0,6),  0, 1, 0);
      rst       = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("mrst.ack",    DATA_W'(req_ack),   DATA_W'(4'h0));
      chk("mrst.ovalid", DATA_W'(out_valid), DATA_W'(1'b0));
      chk("mrst.data",   out_data,           '0);
      chk("mrst.locked", DATA_W'(locked),    DATA_W'(1'b0));
      step("m4", 0, 4'hF, 4'hF, 1, 4'h1, 0, 0, '0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
